uart_receiver: RTL and testbench

Serial-to-parallel UART receiver: the receive end of the UART link that the team's transmit path drives. It oversamples the `rx` line at 16x baud, using a tick from an internal divisor counter. It recovers 1 start bit, `data_bits` data bits (LSB first) and the stop bit, then presents each byte with a one-cycle strobe that the RX FIFO write port consumes. Framing errors are flagged and the byte is discarded.

---
 rtl/uart_pkg.sv | 21 ++
 rtl/uart_receiver_if.sv | 21 ++
 rtl/uart_baud_tick.sv | 28 ++
 rtl/uart_receiver.sv | 145 ++++++++++++++
 tb/tb_uart_receiver.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, oversampling constants and
// the width helper for the per-state tick counter.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } uart_state_e;

  localparam int OVERSAMPLE = 16;
  localparam int MID_TICK   = OVERSAMPLE / 2 - 1;
  localparam int LAST_TICK  = OVERSAMPLE - 1;

  // Must be able to count up to stop_ticks-1; never narrower than one bit period.
  function automatic int tick_cnt_width(input int stop_ticks);
    return (stop_ticks > OVERSAMPLE) ? $clog2(stop_ticks) : $clog2(OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_receiver_if.sv
// Line and byte-side signals of the UART receiver; the receiver takes the slave
// view, whoever drives the line and baud divisor takes the master view.
interface uart_receiver_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic [9:0]           timer_final_value;
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_done_tick;
  logic                 framing_err;

  modport master (
    output rx, timer_final_value,
    input  data_out, rx_done_tick, framing_err
  );

  modport slave (
    input  rx, timer_final_value,
    output data_out, rx_done_tick, framing_err
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Free-running oversample tick generator: one tick every timer_final_value+1 clocks.
// Shared between the UART transmit and receive paths.
module uart_baud_tick (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] timer_final_value,
  output logic       tick
);
  logic [9:0] count_q, count_d;

  // ">=" rather than "==" so a divisor lowered below count ticks at once instead of wrapping.
  always_comb begin
    tick    = 1'b0;
    count_d = count_q + 10'd1;
    if (count_q >= timer_final_value) begin
      tick    = 1'b1;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/uart_receiver.sv
// 16x-oversampling UART receiver: 1 start, data_bits data (LSB first), stop.
// Good frames update data_out with a one-clock rx_done_tick; a low stop bit pulses framing_err.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int data_bits  = 8,
  parameter int stop_ticks = 16
) (
  input  logic           clk,
  input  logic           reset,
  uart_receiver_if.slave bus
);
  localparam int S_W = tick_cnt_width(stop_ticks);
  localparam int N_W = $clog2(data_bits + 1);
  localparam logic [S_W-1:0] S_MID  = S_W'(MID_TICK);
  localparam logic [S_W-1:0] S_LAST = S_W'(LAST_TICK);
  localparam logic [S_W-1:0] S_END  = S_W'(stop_ticks - 1);
  localparam logic [N_W-1:0] N_DONE = N_W'(data_bits);

  logic                 tick;
  logic                 rxs;
  logic                 sync1_q, sync1_d, sync2_q, sync2_d;
  uart_state_e          state_q, state_d;
  logic [S_W-1:0]       s_q, s_d;
  logic [N_W-1:0]       n_q, n_d;
  logic [data_bits-1:0] b_q, b_d;
  logic [data_bits-1:0] data_out_q, data_out_d;
  logic                 stop_ok_q, stop_ok_d;
  logic                 done_q, done_d;
  logic                 ferr_q, ferr_d;

  uart_baud_tick u_baud_tick (
    .clk               (clk),
    .reset             (reset),
    .timer_final_value (bus.timer_final_value),
    .tick              (tick)
  );

  assign rxs = sync2_q;

  always_comb begin
    sync1_d    = bus.rx;
    sync2_d    = sync1_q;
    state_d    = state_q;
    s_d        = s_q;
    n_d        = n_q;
    b_d        = b_q;
    data_out_d = data_out_q;
    stop_ok_d  = stop_ok_q;
    done_d     = 1'b0;
    ferr_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rxs) begin
          s_d     = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          if (s_q == S_MID) begin
            if (!rxs) begin
              s_d     = '0;
              n_d     = '0;
              state_d = DATA;
            end else begin
              state_d = IDLE;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      DATA: begin
        // After the last shift, linger half a bit so STOP counts from the stop-bit edge.
        if (tick) begin
          if (n_q == N_DONE) begin
            if (s_q == S_MID) begin
              s_d     = '0;
              state_d = STOP;
            end else begin
              s_d = s_q + 1'b1;
            end
          end else if (s_q == S_LAST) begin
            b_d = {rxs, b_q[data_bits-1:1]};
            s_d = '0;
            n_d = n_q + 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (s_q == S_MID) begin
            stop_ok_d = rxs;
          end
          if (s_q == S_END) begin
            state_d = IDLE;
            if (stop_ok_q) begin
              data_out_d = b_q;
              done_d     = 1'b1;
            end else begin
              ferr_d = 1'b1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q    <= 1'b1;
      sync2_q    <= 1'b1;
      state_q    <= IDLE;
      s_q        <= '0;
      n_q        <= '0;
      b_q        <= '0;
      data_out_q <= '0;
      stop_ok_q  <= 1'b0;
      done_q     <= 1'b0;
      ferr_q     <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      state_q    <= state_d;
      s_q        <= s_d;
      n_q        <= n_d;
      b_q        <= b_d;
      data_out_q <= data_out_d;
      stop_ok_q  <= stop_ok_d;
      done_q     <= done_d;
      ferr_q     <= ferr_d;
    end
  end

  assign bus.data_out     = data_out_q;
  assign bus.rx_done_tick = done_q;
  assign bus.framing_err  = ferr_q;
endmodule

// File: tb/tb_uart_receiver.sv
// Bench for uart_receiver: two instances (1 and 2 stop bits), directed frames,
// expected bytes queued at stimulus time and popped by per-instance monitors.
module tb_uart_receiver;
  localparam int TFV_A = 9;
  localparam int BIT_A = (TFV_A + 1) * 16;
  localparam int BIT_B = 16;
  // Stop-bit mid-sample: middle of bit 9 plus 3 clocks of sync/edge detect; done 24 ticks later.
  localparam int STOP_MID_B = 9 * BIT_B + BIT_B / 2 + 3;
  localparam int LAT_B      = STOP_MID_B + 24;

  typedef struct {
    bit         err;
    logic [7:0] data;
    int         start_cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  bit   prev_a = 1'b0;
  bit   prev_b = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_receiver_if #(.DATA_BITS(8)) if_a ();
  uart_receiver_if #(.DATA_BITS(8)) if_b ();

  uart_receiver #(.data_bits(8), .stop_ticks(16)) dut_a (
    .clk   (clk),
    .reset (reset),
    .bus   (if_a.slave)
  );

  uart_receiver #(.data_bits(8), .stop_ticks(32)) dut_b (
    .clk   (clk),
    .reset (reset),
    .bus   (if_b.slave)
  );

  always @(negedge clk) begin : mon_a
    exp_t e;
    if (if_a.rx_done_tick || if_a.framing_err) begin
      tests_run++;
      if (if_a.rx_done_tick && if_a.framing_err) begin
        tests_failed++;
        $display("FAIL a_pulse_overlap: done=1 framing_err=1, required only one");
      end else if (prev_a) begin
        tests_failed++;
        $display("FAIL a_pulse_width: pulse high 2 clocks, required 1");
      end else if (q_a.size() == 0) begin
        tests_failed++;
        $display("FAIL a_unexpected: done=%0b ferr=%0b data_out=%h, required no pulse",
                 if_a.rx_done_tick, if_a.framing_err, if_a.data_out);
      end else begin
        e = q_a.pop_front();
        if (e.err != if_a.framing_err || (!e.err && if_a.data_out !== e.data)) begin
          tests_failed++;
          $display("FAIL a_frame: ferr=%0b data_out=%h, required ferr=%0b data_out=%h",
                   if_a.framing_err, if_a.data_out, e.err, e.data);
        end else begin
          $display("[TB] a: %s data_out=%h", e.err ? "framing_err" : "rx_done", if_a.data_out);
        end
      end
    end
    prev_a = if_a.rx_done_tick || if_a.framing_err;
  end

  always @(negedge clk) begin : mon_b
    exp_t e;
    if (if_b.rx_done_tick || if_b.framing_err) begin
      tests_run++;
      if (if_b.rx_done_tick && if_b.framing_err) begin
        tests_failed++;
        $display("FAIL b_pulse_overlap: done=1 framing_err=1, required only one");
      end else if (prev_b) begin
        tests_failed++;
        $display("FAIL b_pulse_width: pulse high 2 clocks, required 1");
      end else if (q_b.size() == 0) begin
        tests_failed++;
        $display("FAIL b_unexpected: done=%0b ferr=%0b data_out=%h, required no pulse",
                 if_b.rx_done_tick, if_b.framing_err, if_b.data_out);
      end else begin
        e = q_b.pop_front();
        if (e.err != if_b.framing_err || (!e.err && if_b.data_out !== e.data)
            || (!e.err && (cyc - e.start_cyc) != LAT_B)) begin
          tests_failed++;
          $display("FAIL b_frame: ferr=%0b data_out=%h latency=%0d, required ferr=%0b data_out=%h latency=%0d",
                   if_b.framing_err, if_b.data_out, cyc - e.start_cyc, e.err, e.data, LAT_B);
        end else begin
          $display("[TB] b: %s data_out=%h latency=%0d", e.err ? "framing_err" : "rx_done",
                   if_b.data_out, cyc - e.start_cyc);
        end
      end
    end
    prev_b = if_b.rx_done_tick || if_b.framing_err;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_rx(input int sel, input logic v);
    if (sel == 0) if_a.rx = v;
    else          if_b.rx = v;
  endtask

  // exp_kind: 0 = no output expected, 1 = good byte, 2 = framing error
  task automatic send_frame(input int sel, input logic [7:0] d, input logic stop_v,
                            input int nstop, input int exp_kind);
    int   bpc;
    exp_t e;
    bpc         = (sel == 0) ? BIT_A : BIT_B;
    e.err       = (exp_kind == 2);
    e.data      = d;
    e.start_cyc = cyc;
    if (exp_kind != 0) begin
      if (sel == 0) q_a.push_back(e);
      else          q_b.push_back(e);
    end
    set_rx(sel, 1'b0);
    hold(bpc);
    for (int i = 0; i < 8; i++) begin
      set_rx(sel, d[i]);
      hold(bpc);
    end
    set_rx(sel, stop_v);
    hold(bpc * nstop);
    set_rx(sel, 1'b1);
  endtask

  task automatic drain(input int sel, input int max_clk);
    int k;
    int pending;
    k       = 0;
    pending = (sel == 0) ? q_a.size() : q_b.size();
    while (k < max_clk && pending != 0) begin
      @(negedge clk);
      k++;
      pending = (sel == 0) ? q_a.size() : q_b.size();
    end
    tests_run++;
    if (pending != 0) begin
      tests_failed++;
      $display("FAIL drain_%s: %0d responses pending after %0d clocks, required 0",
               (sel == 0) ? "a" : "b", pending, max_clk);
      if (sel == 0) q_a.delete();
      else          q_b.delete();
    end
  endtask

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp_v);
    tests_run++;
    if (act !== exp_v) begin
      tests_failed++;
      $display("FAIL %s: got %h, required %h", nm, act, exp_v);
    end else begin
      $display("[TB] %s = %h", nm, act);
    end
  endtask

  initial begin
    if_a.rx = 1'b1;
    if_b.rx = 1'b1;
    if_a.timer_final_value = 10'(TFV_A);
    if_b.timer_final_value = 10'd0;
    reset = 1'b0;
    hold(3);
    check("a_reset_data_out", if_a.data_out, 8'h00);
    check("a_reset_done", {7'd0, if_a.rx_done_tick}, 8'h00);
    check("a_reset_ferr", {7'd0, if_a.framing_err}, 8'h00);
    check("b_reset_data_out", if_b.data_out, 8'h00);
    check("b_reset_done", {7'd0, if_b.rx_done_tick}, 8'h00);
    check("b_reset_ferr", {7'd0, if_b.framing_err}, 8'h00);
    reset = 1'b1;
    hold(BIT_A);

    // single good frame
    send_frame(0, 8'h9A, 1'b1, 1, 1);
    drain(0, BIT_A);
    hold(BIT_A);
    check("a_hold_9a", if_a.data_out, 8'h9A);

    // back-to-back, no idle gap
    send_frame(0, 8'h6B, 1'b1, 1, 1);
    send_frame(0, 8'hC8, 1'b1, 1, 1);
    drain(0, BIT_A);
    check("a_b2b_last", if_a.data_out, 8'hC8);

    // 3-tick glitch, then a real frame
    set_rx(0, 1'b0);
    hold(3 * (TFV_A + 1));
    set_rx(0, 1'b1);
    hold(2 * BIT_A);
    send_frame(0, 8'h35, 1'b1, 1, 1);
    drain(0, BIT_A);
    check("a_after_glitch", if_a.data_out, 8'h35);

    // good frame, then a low stop bit
    send_frame(0, 8'h9A, 1'b1, 1, 1);
    drain(0, BIT_A);
    send_frame(0, 8'h35, 1'b0, 1, 2);
    drain(0, BIT_A);
    hold(2 * BIT_A);
    check("a_ferr_keeps", if_a.data_out, 8'h9A);

    // reset pulse in the middle of the data bits
    set_rx(0, 1'b0);
    hold(4 * BIT_A + BIT_A / 2);
    set_rx(0, 1'b1);
    reset = 1'b0;
    hold(1);
    check("a_midreset_data_out", if_a.data_out, 8'h00);
    check("a_midreset_done", {7'd0, if_a.rx_done_tick}, 8'h00);
    check("a_midreset_ferr", {7'd0, if_a.framing_err}, 8'h00);
    reset = 1'b1;
    hold(2 * BIT_A);
    send_frame(0, 8'hC8, 1'b1, 1, 1);
    drain(0, BIT_A);
    hold(BIT_A);
    check("a_after_reset", if_a.data_out, 8'hC8);

    // divisor 0 with two stop bits
    send_frame(1, 8'hFF, 1'b1, 2, 1);
    hold(BIT_B);
    drain(1, 4 * BIT_B);
    check("b_ff", if_b.data_out, 8'hFF);
    send_frame(1, 8'h00, 1'b1, 2, 1);
    hold(BIT_B);
    drain(1, 4 * BIT_B);
    check("b_00", if_b.data_out, 8'h00);

    hold(4);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule
